// File: rtl/cve2_alu_arb.sv
// cve2_alu_arb: two-requester round-robin front end for a shared ALU.
// Each granted operation is captured, issued to the ALU for one or two cycles,
// and returned as a one-cycle one-hot response strobe with a registered result.
// Optional macro CVE2_ALU_ARB_FLUSH_EN adds flush_i to abandon in-flight work.
module cve2_alu_arb #(
  parameter int unsigned OP_W = 7
) (
  input  logic            clk_i,
  input  logic            rst_ni,
`ifdef CVE2_ALU_ARB_FLUSH_EN
  input  logic            flush_i,
`endif
  input  logic            req0_valid_i,
  input  logic [OP_W-1:0] req0_op_i,
  input  logic [31:0]     req0_a_i,
  input  logic [31:0]     req0_b_i,
  input  logic            req0_two_cycle_i,
  output logic            req0_gnt_o,
  input  logic            req1_valid_i,
  input  logic [OP_W-1:0] req1_op_i,
  input  logic [31:0]     req1_a_i,
  input  logic [31:0]     req1_b_i,
  input  logic            req1_two_cycle_i,
  output logic            req1_gnt_o,
  output logic [1:0]      rsp_valid_o,
  output logic [31:0]     rsp_result_o,
  output logic            busy_o,
  output logic [OP_W-1:0] alu_operator_o,
  output logic [31:0]     alu_operand_a_o,
  output logic [31:0]     alu_operand_b_o,
  output logic            alu_instr_first_cycle_o,
  input  logic [31:0]     alu_result_i,
  input  logic [63:0]     alu_imd_val_d_i,
  input  logic [1:0]      alu_imd_val_we_i,
  output logic [63:0]     alu_imd_val_q_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC1 = 2'd1,
    S_EXEC2 = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e          r_state;
  state_e          w_next;
  logic [1:0]      w_gnt;
  logic            w_win;
  logic            w_flush;

  logic [OP_W-1:0] r_op;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic            r_two;
  logic            r_id;
  logic            r_rr_ptr;
  logic [31:0]     r_result;
  logic [63:0]     r_imd;
  logic [1:0]      r_rsp_valid;
  logic            r_busy;
  logic            r_first;

`ifdef CVE2_ALU_ARB_FLUSH_EN
  assign w_flush = flush_i;
`else
  assign w_flush = 1'b0;
`endif

  // Next-state and grant decode; grants exist only in IDLE.
  always_comb begin
    w_next = r_state;
    w_gnt  = 2'b00;
    w_win  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_flush && (req0_valid_i || req1_valid_i)) begin
          // r_rr_ptr names the requester that did not win last time.
          if (req0_valid_i && req1_valid_i) begin
            w_win = r_rr_ptr;
          end else begin
            w_win = req1_valid_i;
          end
          w_gnt  = w_win ? 2'b10 : 2'b01;
          w_next = S_EXEC1;
        end
      end
      S_EXEC1: begin
        if (w_flush) begin
          w_next = S_IDLE;
        end else if (r_two) begin
          w_next = S_EXEC2;
        end else begin
          w_next = S_RESP;
        end
      end
      S_EXEC2: begin
        w_next = w_flush ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operation capture, intermediate storage, result and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_two       <= 1'b0;
      r_id        <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_result    <= '0;
      r_imd       <= '0;
      r_rsp_valid <= 2'b00;
      r_busy      <= 1'b0;
      r_first     <= 1'b0;
    end else begin
      if (w_gnt != 2'b00) begin
        r_op     <= w_win ? req1_op_i : req0_op_i;
        r_a      <= w_win ? req1_a_i : req0_a_i;
        r_b      <= w_win ? req1_b_i : req0_b_i;
        r_two    <= w_win ? req1_two_cycle_i : req0_two_cycle_i;
        r_id     <= w_win;
        r_rr_ptr <= ~w_win;
        r_imd    <= '0;
      end
      if (w_flush && (r_state != S_IDLE)) begin
        r_imd <= '0;
      end else if (r_state == S_EXEC1) begin
        if (r_two) begin
          if (alu_imd_val_we_i[0]) r_imd[31:0]  <= alu_imd_val_d_i[31:0];
          if (alu_imd_val_we_i[1]) r_imd[63:32] <= alu_imd_val_d_i[63:32];
        end else begin
          r_result <= alu_result_i;
        end
      end else if (r_state == S_EXEC2) begin
        r_result <= alu_result_i;
      end
      r_rsp_valid <= (w_next == S_RESP) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
      r_busy      <= (w_next != S_IDLE);
      r_first     <= (w_next == S_EXEC1);
    end
  end

  assign req0_gnt_o              = w_gnt[0];
  assign req1_gnt_o              = w_gnt[1];
  assign rsp_valid_o             = r_rsp_valid;
  assign rsp_result_o            = r_result;
  assign busy_o                  = r_busy;
  assign alu_operator_o          = r_op;
  assign alu_operand_a_o         = r_a;
  assign alu_operand_b_o         = r_b;
  assign alu_instr_first_cycle_o = r_first;
  assign alu_imd_val_q_o         = r_imd;

endmodule

// File: tb/tb_cve2_alu_arb.sv
// Directed self-checking bench for cve2_alu_arb with a tiny ALU model
// (op 0 = add, op 1 = sub, others = xor).
module tb_cve2_alu_arb;

  localparam int unsigned OP_W = 7;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            v0, v1, t0, t1, g0, g1;
  logic [OP_W-1:0] op0, op1, alu_op;
  logic [31:0]     a0, b0, a1, b1;
  logic [1:0]      rsp_valid;
  logic [31:0]     rsp_result, alu_a, alu_b, alu_res;
  logic            busy, first;
  logic [63:0]     imd_d, imd_q;
  logic [1:0]      imd_we;

  int total = 0;
  int bad   = 0;

  cve2_alu_arb #(.OP_W(OP_W)) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
`ifdef CVE2_ALU_ARB_FLUSH_EN
    .flush_i                 (flush),
`endif
    .req0_valid_i            (v0),
    .req0_op_i               (op0),
    .req0_a_i                (a0),
    .req0_b_i                (b0),
    .req0_two_cycle_i        (t0),
    .req0_gnt_o              (g0),
    .req1_valid_i            (v1),
    .req1_op_i               (op1),
    .req1_a_i                (a1),
    .req1_b_i                (b1),
    .req1_two_cycle_i        (t1),
    .req1_gnt_o              (g1),
    .rsp_valid_o             (rsp_valid),
    .rsp_result_o            (rsp_result),
    .busy_o                  (busy),
    .alu_operator_o          (alu_op),
    .alu_operand_a_o         (alu_a),
    .alu_operand_b_o         (alu_b),
    .alu_instr_first_cycle_o (first),
    .alu_result_i            (alu_res),
    .alu_imd_val_d_i         (imd_d),
    .alu_imd_val_we_i        (imd_we),
    .alu_imd_val_q_o         (imd_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU fed from the arbiter outputs.
  always_comb begin
    case (alu_op)
      7'd0:    alu_res = alu_a + alu_b;
      7'd1:    alu_res = alu_a - alu_b;
      default: alu_res = alu_a ^ alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    v0 = 0; v1 = 0; t0 = 0; t1 = 0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    imd_d = '0; imd_we = 2'b00;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp", 64'(rsp_valid), 64'd0);
    check("rst_imd", imd_q, 64'd0);
    check("rst_opa", 64'(alu_a), 64'd0);
    check("rst_first", 64'(first), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Req0 single-cycle add 5+7
    v0 = 1; op0 = 7'd0; a0 = 32'd5; b0 = 32'd7; t0 = 0;
    #1;
    check("add_gnt0", 64'(g0), 64'd1);
    check("add_gnt1", 64'(g1), 64'd0);
    tick();                                   // EXEC1 (T+1)
    v0 = 0;
    check("add_first", 64'(first), 64'd1);
    check("add_busy", 64'(busy), 64'd1);
    check("add_opb", 64'(alu_b), 64'd7);
    check("add_rsp_early", 64'(rsp_valid), 64'd0);
    tick();                                   // RESP (T+2)
    check("add_rsp", 64'(rsp_valid), 64'd1);
    check("add_res", 64'(rsp_result), 64'd12);
    check("add_first_resp", 64'(first), 64'd0);
    tick();                                   // IDLE
    check("add_rsp_done", 64'(rsp_valid), 64'd0);
    check("add_idle_busy", 64'(busy), 64'd0);
    check("add_res_hold", 64'(rsp_result), 64'd12);

    // Req1 two-cycle sub 5-3, operand change after grant
    v1 = 1; op1 = 7'd1; a1 = 32'd5; b1 = 32'd3; t1 = 1;
    #1;
    check("two_gnt1", 64'(g1), 64'd1);
    check("two_gnt0", 64'(g0), 64'd0);
    tick();                                   // EXEC1
    a1 = 32'd9;
    imd_we = 2'b11; imd_d = 64'hAAAA_0000_5555_0000;
    #1;
    check("two_no_gnt_busy", 64'(g1), 64'd0);
    check("two_opa_e1", 64'(alu_a), 64'd5);
    check("two_first", 64'(first), 64'd1);
    tick();                                   // EXEC2
    imd_d = 64'hFFFF_FFFF_FFFF_FFFF;          // must be ignored in EXEC2
    check("two_imd_e2", imd_q, 64'hAAAA_0000_5555_0000);
    check("two_opa_e2", 64'(alu_a), 64'd5);
    check("two_first_e2", 64'(first), 64'd0);
    check("two_rsp_e2", 64'(rsp_valid), 64'd0);
    tick();                                   // RESP (T+3)
    v1 = 0; imd_we = 2'b00; imd_d = '0;
    check("two_rsp", 64'(rsp_valid), 64'd2);
    check("two_res", 64'(rsp_result), 64'd2);
    check("two_imd_hold", imd_q, 64'hAAAA_0000_5555_0000);
    tick();                                   // IDLE
    check("two_rsp_done", 64'(rsp_valid), 64'd0);

    // Both requesters held valid: grants alternate 0,1,0,1
    v0 = 1; op0 = 7'd0; a0 = 32'd1;  b0 = 32'd1;  t0 = 0;
    v1 = 1; op1 = 7'd0; a1 = 32'd10; b1 = 32'd10; t1 = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_gnt0", 64'(g0), 64'((i % 2) == 0));
      check("rr_gnt1", 64'(g1), 64'((i % 2) == 1));
      tick();                                 // EXEC1
      if (i == 0) check("rr_imd_clr", imd_q, 64'd0);
      tick();                                 // RESP
      check("rr_rsp", 64'(rsp_valid), ((i % 2) == 0) ? 64'd1 : 64'd2);
      check("rr_res", 64'(rsp_result), ((i % 2) == 0) ? 64'd2 : 64'd20);
      tick();                                 // IDLE
    end
    v0 = 0; v1 = 0;

    // Reset during EXEC2 after a req0 grant (pointer now favours req1)
    v0 = 1; t0 = 1;
    #1;
    check("rst_gnt0", 64'(g0), 64'd1);
    tick();                                   // EXEC1
    v0 = 0;
    tick();                                   // EXEC2
    check("rst_e2_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_rsp", 64'(rsp_valid), 64'd0);
    check("rst_mid_res", 64'(rsp_result), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_no_pulse", 64'(rsp_valid), 64'd0);
    v0 = 1; v1 = 1; t0 = 0; t1 = 0;
    #1;
    check("rst_ptr_gnt0", 64'(g0), 64'd1);
    check("rst_ptr_gnt1", 64'(g1), 64'd0);
    tick();
    v0 = 0; v1 = 0;
    tick();                                   // RESP
    check("rst_after_rsp", 64'(rsp_valid), 64'd1);
    tick();

`ifdef CVE2_ALU_ARB_FLUSH_EN
    // Flush in EXEC1 abandons the op and clears intermediates
    v1 = 1; t1 = 1;
    #1;
    check("fl_gnt1", 64'(g1), 64'd1);
    tick();                                   // EXEC1
    v1 = 0; flush = 1; imd_we = 2'b11; imd_d = 64'h1234_5678_9ABC_DEF0;
    tick();                                   // IDLE
    flush = 0; imd_we = 2'b00;
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_rsp", 64'(rsp_valid), 64'd0);
    check("fl_imd", imd_q, 64'd0);
    tick();
    check("fl_rsp_late", 64'(rsp_valid), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
